// File: rtl/oai_pkg.sv
// Shared definitions for the OAI/AOI reduction pipeline:
// mode encodings and the flat DIN bit-index helper.
package oai_pkg;

  localparam logic MODE_OAI = 1'b0;
  localparam logic MODE_AOI = 1'b1;

  // Lane l, group g, input k -> bit position in the flat DIN bus.
  function automatic int din_idx(
    input int l,
    input int g,
    input int k,
    input int groups,
    input int group_w
  );
    return (l * groups + g) * group_w + k;
  endfunction

endpackage

// File: rtl/oai_grp_reduce.sv
// Per-lane group reduction: OR of each group (OAI) or AND (AOI).
// Ports: din_i (one lane's inputs), mode_i, red_o (one bit per group).
module oai_grp_reduce
  import oai_pkg::*;
#(
  parameter int GROUPS  = 3,
  parameter int GROUP_W = 2
) (
  input  logic [GROUPS*GROUP_W-1:0] din_i,
  input  logic                      mode_i,
  output logic [GROUPS-1:0]         red_o
);

  always_comb begin
    red_o = '0;
    for (int g = 0; g < GROUPS; g++) begin
      if (mode_i == MODE_AOI)
        red_o[g] = &din_i[din_idx(0, g, 0, GROUPS, GROUP_W) +: GROUP_W];
      else
        red_o[g] = |din_i[din_idx(0, g, 0, GROUPS, GROUP_W) +: GROUP_W];
    end
  end

endmodule

// File: rtl/oai_nxm_pipe.sv
// Two-stage pipelined OAI/AOI array with valid/ready handshake.
// Ports: CLK, RN, MODE, IN_VALID/IN_READY, DIN, OUT_VALID/OUT_READY, ZN.
module oai_nxm_pipe
  import oai_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int GROUPS  = 3,
  parameter int GROUP_W = 2
) (
  input  logic                              CLK,
  input  logic                              RN,
  input  logic                              MODE,
  input  logic                              IN_VALID,
  output logic                              IN_READY,
  input  logic [LANES*GROUPS*GROUP_W-1:0]   DIN,
  output logic                              OUT_VALID,
  input  logic                              OUT_READY,
  output logic [LANES-1:0]                  ZN
);

  localparam int LW = GROUPS * GROUP_W;
  localparam int RW = LANES * GROUPS;

  if (LANES < 1 || GROUPS < 1 || GROUP_W < 1) begin : g_bad_param
    $fatal(1, "oai_nxm_pipe: LANES, GROUPS, GROUP_W must be >= 1");
  end

  logic [RW-1:0]    red_d;
  logic [RW-1:0]    red_q;
  logic             mode_q;
  logic             v1_q;
  logic [LANES-1:0] zn_d;
  logic [LANES-1:0] zn_q;
  logic             v2_q;
  logic             s1_en;
  logic             s2_en;
  logic             acc;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int BASE = din_idx(l, 0, 0, GROUPS, GROUP_W);

    oai_grp_reduce #(
      .GROUPS  (GROUPS),
      .GROUP_W (GROUP_W)
    ) u_red (
      .din_i  (DIN[BASE +: LW]),
      .mode_i (MODE),
      .red_o  (red_d[l*GROUPS +: GROUPS])
    );

    // Second level uses the mode captured with this item, not live MODE.
    assign zn_d[l] = (mode_q == MODE_AOI)
                   ? ~|red_q[l*GROUPS +: GROUPS]
                   : ~&red_q[l*GROUPS +: GROUPS];
  end

  assign s2_en    = ~v2_q | OUT_READY;
  assign s1_en    = ~v1_q | s2_en;
  assign IN_READY = s1_en;
  assign acc      = IN_VALID & s1_en;

  always_ff @(posedge CLK or negedge RN) begin
    if (!RN) begin
      red_q  <= '0;
      mode_q <= MODE_OAI;
      v1_q   <= 1'b0;
      zn_q   <= '0;
      v2_q   <= 1'b0;
    end else begin
      if (s1_en) begin
        v1_q <= acc;
        // Data regs only load on accept, so idle DIN never reaches ZN.
        if (acc) begin
          red_q  <= red_d;
          mode_q <= MODE;
        end
      end
      if (s2_en) begin
        v2_q <= v1_q;
        if (v1_q)
          zn_q <= zn_d;
      end
    end
  end

  assign OUT_VALID = v2_q;
  assign ZN        = zn_q;

endmodule

// File: tb/tb_oai_nxm_pipe.sv
// Directed and scoreboard bench for oai_nxm_pipe,
// including the degenerate and wide parameter sets.
module tb_oai_nxm_pipe;

  logic        clk;
  logic        rn;
  logic        mode;
  logic        iv;
  logic        ir;
  logic [23:0] din;
  logic        ov;
  logic        ordy;
  logic [3:0]  zn;

  logic        m1, iv1, ir1, ov1;
  logic [0:0]  din1;
  logic [0:0]  zn1;
  logic        m8, iv8, ir8, ov8;
  logic [95:0] din8;
  logic [7:0]  zn8;

  int n_chk  = 0;
  int n_fail = 0;
  int n_take = 0;
  logic [3:0] q[$];

  oai_nxm_pipe dut (
    .CLK(clk), .RN(rn), .MODE(mode), .IN_VALID(iv), .IN_READY(ir),
    .DIN(din), .OUT_VALID(ov), .OUT_READY(ordy), .ZN(zn)
  );

  oai_nxm_pipe #(.LANES(1), .GROUPS(1), .GROUP_W(1)) dut1 (
    .CLK(clk), .RN(rn), .MODE(m1), .IN_VALID(iv1), .IN_READY(ir1),
    .DIN(din1), .OUT_VALID(ov1), .OUT_READY(1'b1), .ZN(zn1)
  );

  oai_nxm_pipe #(.LANES(8), .GROUPS(4), .GROUP_W(3)) dut8 (
    .CLK(clk), .RN(rn), .MODE(m8), .IN_VALID(iv8), .IN_READY(ir8),
    .DIN(din8), .OUT_VALID(ov8), .OUT_READY(1'b1), .ZN(zn8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // Reference: OR/AND per group, then AND/OR across groups, inverted.
  function automatic logic [7:0] model(input logic [95:0] d, input logic m,
                                       input int nl, input int ng,
                                       input int nw);
    logic [7:0] r;
    logic t, gb, b;
    r = '0;
    for (int l = 0; l < nl; l++) begin
      t = m ? 1'b0 : 1'b1;
      for (int g = 0; g < ng; g++) begin
        gb = m ? 1'b1 : 1'b0;
        for (int k = 0; k < nw; k++) begin
          b  = d[(l * ng + g) * nw + k];
          gb = m ? (gb & b) : (gb | b);
        end
        t = m ? (t | gb) : (t & gb);
      end
      r[l] = ~t;
    end
    return r;
  endfunction

  // One clock of the main DUT: drive after negedge, judge handshake
  // before the posedge, score any output taken on that edge.
  task automatic cyc(input logic v, input logic m, input logic [23:0] d,
                     input logic o, input logic [3:0] x,
                     input logic ck_r, input logic er, output logic a);
    logic t;
    logic [3:0] e;
    @(negedge clk);
    iv = v; mode = m; din = d; ordy = o;
    #1;
    if (ck_r) begin
      n_chk++;
      if (ir !== er) begin
        n_fail++;
        $display("FAIL in_ready: got %b want %b at %0t", ir, er, $time);
      end
    end
    a = iv & ir;
    t = ov & ordy;
    if (t) begin
      n_chk++;
      n_take++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_output: zn=%h with empty queue", zn);
      end else begin
        e = q.pop_front();
        if (zn !== e) begin
          n_fail++;
          $display("FAIL zn_order: got %h want %h at %0t", zn, e, $time);
        end
      end
    end
    if (a) q.push_back(x);
  endtask

  task automatic drain();
    logic a;
    for (int i = 0; i < 10 && q.size() != 0; i++)
      cyc(1'b0, 1'b0, 24'h0, 1'b1, 4'h0, 1'b0, 1'b0, a);
    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d items left, want 0", q.size());
    end
  endtask

  // Hand-computed vectors: {lane3,lane2,lane1,lane0}, 6 bits each.
  localparam logic [23:0] D1 = {6'b010101, 6'b000000, 6'b111111, 6'b000110};
  localparam logic [23:0] D2 = {6'b101010, 6'b100000, 6'b001111, 6'b110110};
  localparam logic [23:0] D3 = {6'b000000, 6'b111111, 6'b000011, 6'b110000};

  task automatic test_reset();
    logic a;
    rn = 1'b0; iv = 1'b0; ordy = 1'b0; mode = 1'b0; din = '0;
    #1;
    n_chk++;
    if (ov !== 1'b0 || zn !== 4'h0 || ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_init: ov=%b zn=%h ir=%b want 0 0 1", ov, zn, ir);
    end
    @(negedge clk);
    rn = 1'b1;
    cyc(1'b1, 1'b0, D1, 1'b1, 4'b0101, 1'b0, 1'b0, a);
    cyc(1'b1, 1'b0, D2, 1'b1, 4'b0110, 1'b0, 1'b0, a);
    @(posedge clk);
    #1;
    n_chk++;
    if (ov !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: ov=%b want 1 before reset", ov);
    end
    iv = 1'b0; ordy = 1'b0;
    #1;
    rn = 1'b0;
    #1;
    n_chk++;
    if (ov !== 1'b0 || zn !== 4'h0 || ir !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid: ov=%b zn=%h ir=%b want 0 0 1", ov, zn, ir);
    end
    q.delete();
    @(negedge clk);
    rn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 1'b0, 24'hffffff, 1'b1, 4'h0, 1'b0, 1'b0, a);
      n_chk++;
      if (ov !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_stale: ov=%b want 0 cycle %0d", ov, i);
      end
    end
  endtask

  task automatic test_oai_truth();
    logic a;
    cyc(1'b1, 1'b0, D1, 1'b1, 4'b0101, 1'b1, 1'b1, a);
    @(posedge clk);
    #1;
    iv = 1'b0;
    n_chk++;
    if (ov !== 1'b0) begin
      n_fail++;
      $display("FAIL latency_early: ov=%b want 0 after accept edge", ov);
    end
    @(posedge clk);
    #1;
    n_chk++;
    if (ov !== 1'b1 || zn[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL latency_out: ov=%b zn0=%b want 1 1", ov, zn[0]);
    end
    cyc(1'b1, 1'b0, D2, 1'b1, 4'b0110, 1'b1, 1'b1, a);
    drain();
  endtask

  task automatic test_aoi_mixed();
    logic a;
    for (int i = 0; i < 4; i++)
      cyc(1'b1, i[0], D3, 1'b1, i[0] ? 4'b1000 : 4'b1011, 1'b1, 1'b1, a);
    cyc(1'b1, 1'b1, D1, 1'b1, 4'b1101, 1'b1, 1'b1, a);
    drain();
  endtask

  task automatic test_backpressure();
    logic [23:0] td[5];
    logic        tm[5];
    logic [3:0]  tx[5];
    logic a;
    int   k;
    int   t0;
    td = '{D1, D2, D3, D3, D1};
    tm = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    tx = '{4'b0101, 4'b0110, 4'b1011, 4'b1000, 4'b1101};
    t0 = n_take;
    cyc(1'b1, tm[0], td[0], 1'b0, tx[0], 1'b1, 1'b1, a);
    cyc(1'b1, tm[1], td[1], 1'b0, tx[1], 1'b1, 1'b1, a);
    for (int i = 0; i < 2; i++) begin
      cyc(1'b1, tm[2], td[2], 1'b0, tx[2], 1'b1, 1'b0, a);
      n_chk++;
      if (ov !== 1'b1 || zn !== tx[0]) begin
        n_fail++;
        $display("FAIL bp_hold: ov=%b zn=%h want 1 %h", ov, zn, tx[0]);
      end
    end
    k = 2;
    cyc(1'b1, tm[k], td[k], 1'b1, tx[k], 1'b1, 1'b1, a);
    if (a) k++;
    for (int i = 0; i < 10 && k < 5; i++) begin
      cyc(1'b1, tm[k], td[k], 1'b1, tx[k], 1'b0, 1'b0, a);
      if (a) k++;
    end
    drain();
    n_chk++;
    if (n_take - t0 != 5) begin
      n_fail++;
      $display("FAIL bp_count: took %0d want 5", n_take - t0);
    end
  endtask

  task automatic test_full_rate();
    logic [23:0] d;
    logic [7:0]  x;
    logic        m, a;
    int          t0;
    t0 = n_take;
    for (int i = 0; i < 100; i++) begin
      d = 24'($urandom);
      m = 1'($urandom);
      x = model({72'h0, d}, m, 4, 3, 2);
      cyc(1'b1, m, d, 1'b1, x[3:0], 1'b1, 1'b1, a);
      if (i >= 2) begin
        n_chk++;
        if (ov !== 1'b1) begin
          n_fail++;
          $display("FAIL full_rate_bubble: ov=%b want 1 item %0d", ov, i);
        end
      end
    end
    drain();
    n_chk++;
    if (n_take - t0 != 100) begin
      n_fail++;
      $display("FAIL full_rate_count: took %0d want 100", n_take - t0);
    end
  endtask

  task automatic test_param_sweep();
    logic [7:0] e1[52];
    logic [7:0] e8[52];
    for (int j = 0; j < 52; j++) begin
      @(negedge clk);
      if (j < 50) begin
        iv1 = 1'b1; m1 = 1'($urandom); din1 = 1'($urandom);
        iv8 = 1'b1; m8 = 1'($urandom);
        din8 = {$urandom, $urandom, $urandom};
        e1[j] = model({95'h0, din1}, m1, 1, 1, 1);
        e8[j] = model(din8, m8, 8, 4, 3);
      end else begin
        iv1 = 1'b0; iv8 = 1'b0;
      end
      #1;
      if (j >= 2) begin
        n_chk++;
        if (ov1 !== 1'b1 || zn1 !== e1[j-2][0:0]) begin
          n_fail++;
          $display("FAIL sweep_1x1x1: ov=%b zn=%b want 1 %b", ov1, zn1,
                   e1[j-2][0]);
        end
        n_chk++;
        if (ov8 !== 1'b1 || zn8 !== e8[j-2]) begin
          n_fail++;
          $display("FAIL sweep_8x4x3: ov=%b zn=%h want 1 %h", ov8, zn8,
                   e8[j-2]);
        end
      end
    end
    @(negedge clk);
    n_chk++;
    if (ov1 !== 1'b0 || ov8 !== 1'b0 || ir1 !== 1'b1 || ir8 !== 1'b1) begin
      n_fail++;
      $display("FAIL sweep_idle: ov1=%b ov8=%b ir1=%b ir8=%b want 0 0 1 1",
               ov1, ov8, ir1, ir8);
    end
  endtask

  initial begin
    iv1 = 1'b0; m1 = 1'b0; din1 = '0;
    iv8 = 1'b0; m8 = 1'b0; din8 = '0;
    test_reset();
    test_oai_truth();
    test_aoi_mixed();
    test_backpressure();
    test_full_rate();
    test_param_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
